// File: rtl/neopixel_frame_sequencer.sv
// Frame sequencer for a NeoPixel chain: keeps the colour buffer and streams
// brightness-scaled GRB words to the bit driver, then holds the latch gap.
module neopixel_frame_sequencer #(
    parameter int CLOCK_SPEED_HZ = 32_000_000,
    parameter int NUM_PIXELS     = 8,
    parameter int ADDR_W         = 3,
    parameter int REFRESH_HZ     = 100,
    parameter int LATCH_US       = 80
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_color,
    input  logic [7:0]        brightness,
    input  logic              frame_start,
    input  logic              auto_refresh,
    output logic [23:0]       pixel_color,
    output logic              pixel_valid,
    input  logic              pixel_ready,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_count
);
    localparam int REFRESH_CYCLES = CLOCK_SPEED_HZ / REFRESH_HZ;
    localparam int LATCH_CYCLES   = (CLOCK_SPEED_HZ / 1_000_000) * LATCH_US;
    localparam int IDX_W          = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int REF_W          = $clog2(REFRESH_CYCLES + 1);
    localparam int LAT_W          = $clog2(LATCH_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        FETCH,
        SCALE,
        PRESENT,
        LATCH
    } state_t;

    state_t           state;
    logic [23:0]      buffer [NUM_PIXELS];
    logic [IDX_W-1:0] clear_idx;
    logic [IDX_W-1:0] idx;
    logic [23:0]      fetch_data;
    logic [7:0]       bright_r;
    logic             pending;
    logic [REF_W-1:0] refresh_cnt;
    logic [LAT_W-1:0] latch_cnt;
    logic             refresh_tick;
    logic             request;
    logic             wr_in_range;

    // The +1 makes full brightness an exact identity and zero a hard black.
    function automatic logic [7:0] scale_channel(input logic [7:0] ch, input logic [7:0] level);
        logic [15:0] product;
        product = {8'd0, ch} * ({8'd0, level} + 16'd1);
        return 8'(product >> 8);
    endfunction

    assign refresh_tick = auto_refresh && (refresh_cnt == REF_LAST);
    assign request      = frame_start || refresh_tick;
    assign wr_in_range  = int'(wr_addr) < NUM_PIXELS;
    assign busy         = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset && state == CLEAR) begin
            buffer[clear_idx] <= '0;
        end else if (reset && wr_en && wr_in_range) begin
            buffer[wr_addr[IDX_W-1:0]] <= wr_color;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= CLEAR;
            clear_idx   <= '0;
            idx         <= '0;
            fetch_data  <= '0;
            bright_r    <= '0;
            pending     <= 1'b0;
            refresh_cnt <= '0;
            latch_cnt   <= '0;
            pixel_color <= '0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;

            if (!auto_refresh || refresh_tick) begin
                refresh_cnt <= '0;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end

            // Requests arriving mid-frame merge into a single deferred frame.
            if (request && state != IDLE) begin
                pending <= 1'b1;
            end

            case (state)
                CLEAR: begin
                    if (clear_idx == LAST_IDX) begin
                        state <= IDLE;
                    end else begin
                        clear_idx <= clear_idx + 1'b1;
                    end
                end
                IDLE: begin
                    if (request || pending) begin
                        state    <= FETCH;
                        idx      <= '0;
                        bright_r <= brightness;
                        pending  <= 1'b0;
                    end
                end
                FETCH: begin
                    fetch_data <= buffer[idx];
                    state      <= SCALE;
                end
                SCALE: begin
                    pixel_color <= {scale_channel(fetch_data[15:8], bright_r),
                                    scale_channel(fetch_data[23:16], bright_r),
                                    scale_channel(fetch_data[7:0], bright_r)};
                    pixel_valid <= 1'b1;
                    state       <= PRESENT;
                end
                PRESENT: begin
                    if (pixel_ready) begin
                        pixel_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            latch_cnt <= '0;
                            state     <= LATCH;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                LATCH: begin
                    if (latch_cnt == LAT_LAST) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        state       <= IDLE;
                    end else begin
                        latch_cnt <= latch_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_neopixel_frame_sequencer.sv
// Randomised bench for neopixel_frame_sequencer: a per-frame model of the
// buffer and scaling rules predicts every transferred pixel and its timing.
module tb_neopixel_frame_sequencer;
    localparam int NP             = 4;
    localparam int LATCH_CYCLES   = 2560;
    localparam int REFRESH_CYCLES = 5000;

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [23:0] wr_color;
    logic [7:0]  brightness;
    logic        frame_start;
    logic        auto_refresh;
    logic [23:0] pixel_color;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [23:0] model_buf [NP];
    logic [15:0] exp_frames  = 16'd0;

    always #5 clock = ~clock;

    neopixel_frame_sequencer #(
        .CLOCK_SPEED_HZ(32_000_000),
        .NUM_PIXELS    (NP),
        .ADDR_W        (4),
        .REFRESH_HZ    (6400),
        .LATCH_US      (80)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_color    (wr_color),
        .brightness  (brightness),
        .frame_start (frame_start),
        .auto_refresh(auto_refresh),
        .pixel_color (pixel_color),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    // Reference: each channel is ch*(b+1)/256, output order is G,R,B.
    function automatic logic [23:0] scalePixel(input logic [23:0] rgb, input int b);
        int r, g, bl;
        r  = (int'(rgb[23:16]) * (b + 1)) / 256;
        g  = (int'(rgb[15:8])  * (b + 1)) / 256;
        bl = (int'(rgb[7:0])   * (b + 1)) / 256;
        return {g[7:0], r[7:0], bl[7:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] addr, input logic [23:0] color);
        wr_en    = 1'b1;
        wr_addr  = addr;
        wr_color = color;
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        if (int'(addr) < NP) model_buf[addr] = color;
    endtask

    task automatic waitClear();
        int n    = 0;
        bit idle = 1'b0;
        while (!idle && n < 20) begin
            @(posedge clock);
            n++;
            #1;
            wr_en    = (n == 1);
            wr_addr  = 4'd0;
            wr_color = 24'hABCDEF;
            @(negedge clock);
            idle = !busy;
        end
        wr_en = 1'b0;
        checkOutput("clear_cycles", n, NP);
    endtask

    task automatic idleCheck(input int cycles, input string tag);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
            @(negedge clock);
            if (busy !== 1'b0 || pixel_valid !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        checkOutput(tag, bad, 0);
    endtask

    // ready_mode: 0 ready tied high, 1 random ready, 2 ten-cycle stall on pixel 1.
    task automatic runFrame(input logic [7:0] bright, input int ready_mode, input bit from_pending,
                            input bit inject, input bit midframe, output logic [23:0] first_color);
        logic [23:0] expq [NP];
        logic [23:0] prev_color = '0;
        logic        prev_valid = 1'b0;
        logic        xfer       = 1'b0;
        int          e = 0, px = 0, last_xfer = 0, done_edge = 0, stall = 0, unstable = 0;
        bit          done = 1'b0, latch_valid = 1'b0;
        first_color = '0;
        for (int i = 0; i < NP; i++) expq[i] = scalePixel(model_buf[i], int'(bright));
        brightness = bright;
        if (!from_pending) frame_start = 1'b1;
        while (!done && e < 4000) begin
            @(posedge clock);
            e++;
            #1;
            frame_start = inject && (e == 6 || e == 200);
            wr_en = 1'b0;
            case (ready_mode)
                0: pixel_ready = 1'b1;
                1: pixel_ready = 1'($urandom_range(0, 1));
                default: begin
                    pixel_ready = 1'b1;
                    if (px == 1 && pixel_valid && stall < 10) begin
                        pixel_ready = 1'b0;
                        stall++;
                        if (midframe && stall == 5) begin
                            wr_en    = 1'b1;
                            wr_addr  = 4'd3;
                            wr_color = 24'($urandom);
                            model_buf[3] = wr_color;
                            expq[3] = scalePixel(wr_color, int'(bright));
                        end else if (midframe && stall == 6) begin
                            wr_en    = 1'b1;
                            wr_addr  = 4'd0;
                            wr_color = 24'($urandom);
                            model_buf[0] = wr_color;
                        end
                    end
                end
            endcase
            @(negedge clock);
            if (e == 1) begin
                checkOutput("busy_at_start", busy, 1);
                checkOutput("done_pulse_width", frame_done, 0);
            end
            if (xfer) begin
                if (px == 0) first_color = prev_color;
                if (px < NP) checkOutput($sformatf("pixel%0d_color", px), prev_color, expq[px]);
                checkOutput("valid_drop", pixel_valid, 0);
                px++;
                last_xfer = e;
            end else if (prev_valid && (pixel_valid !== 1'b1 || pixel_color !== prev_color)) begin
                unstable++;
            end
            if (pixel_valid && !prev_valid) begin
                checkOutput("valid_rise_edge", e, (px == 0) ? 3 : last_xfer + 2);
            end
            if (px >= NP && pixel_valid) latch_valid = 1'b1;
            if (frame_done) begin
                done      = 1'b1;
                done_edge = e;
            end
            xfer       = pixel_valid && pixel_ready;
            prev_valid = pixel_valid;
            prev_color = pixel_color;
        end
        frame_start = 1'b0;
        wr_en       = 1'b0;
        checkOutput("frame_finished", done, 1);
        checkOutput("pixels_sent", px, NP);
        checkOutput("latch_gap", done_edge - last_xfer, LATCH_CYCLES);
        exp_frames++;
        checkOutput("frame_count", frame_count, exp_frames);
        checkOutput("busy_after_frame", busy, 0);
        checkOutput("hold_stable", unstable, 0);
        checkOutput("valid_low_in_latch", latch_valid, 0);
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [23:0] col;
        int          rises;
        logic        pv;
        logic        pb;
        int          dones;
        int          starts [$];
        int          n;

        reset        = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_color     = '0;
        brightness   = '0;
        frame_start  = 1'b0;
        auto_refresh = 1'b0;
        pixel_ready  = 1'b0;
        for (int i = 0; i < NP; i++) model_buf[i] = '0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_valid", pixel_valid, 0);
        checkOutput("reset_color", pixel_color, 0);
        checkOutput("reset_done", frame_done, 0);
        checkOutput("reset_count", frame_count, 0);
        checkOutput("reset_busy", busy, 1);
        reset = 1'b1;
        waitClear();

        runFrame(8'd255, 0, 1'b0, 1'b0, 1'b0, col);
        checkOutput("cleared_first_pixel", col, 24'h000000);

        applyStimulus(4'd0, 24'hFF8040);
        runFrame(8'd255, 0, 1'b0, 1'b0, 1'b0, col);
        checkOutput("grb_full_brightness", col, 24'h80FF40);
        runFrame(8'd127, 0, 1'b0, 1'b0, 1'b0, col);
        checkOutput("grb_half_brightness", col, 24'h407F20);

        for (int a = 0; a < NP; a++) applyStimulus(4'(a), 24'($urandom));
        runFrame(8'($urandom), 2, 1'b0, 1'b0, 1'b1, col);

        runFrame(8'($urandom), 0, 1'b0, 1'b1, 1'b0, col);
        runFrame(8'($urandom), 0, 1'b1, 1'b0, 1'b0, col);
        idleCheck(30, "no_extra_frame");

        for (int f = 0; f < 4; f++) begin
            for (int w = 0; w < 3; w++) applyStimulus(4'($urandom_range(0, 7)), 24'($urandom));
            runFrame(8'($urandom), 1, 1'b0, 1'b0, 1'b0, col);
        end

        auto_refresh = 1'b1;
        pixel_ready  = 1'b1;
        pb           = busy;
        dones        = 0;
        for (int k = 1; k <= 3 * REFRESH_CYCLES + 100; k++) begin
            @(posedge clock);
            #1;
            wr_en    = (k % 1000 == 0);
            wr_addr  = 4'd9;
            wr_color = 24'($urandom);
            @(negedge clock);
            if (busy && !pb) starts.push_back(k);
            if (frame_done) dones++;
            pb = busy;
        end
        wr_en        = 1'b0;
        auto_refresh = 1'b0;
        n = 0;
        while (dones < 3 && n < 3000) begin
            @(posedge clock);
            n++;
            #1;
            @(negedge clock);
            if (frame_done) dones++;
        end
        checkOutput("refresh_frames", starts.size(), 3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("refresh_start%0d", i),
                        (i < starts.size()) ? starts[i] : -1, (i + 1) * REFRESH_CYCLES);
        end
        checkOutput("refresh_done_count", dones, 3);
        exp_frames += 16'd3;
        checkOutput("refresh_frame_count", frame_count, exp_frames);
        runFrame(8'd255, 0, 1'b0, 1'b0, 1'b0, col);

        brightness  = 8'd255;
        pixel_ready = 1'b1;
        frame_start = 1'b1;
        rises       = 0;
        pv          = 1'b0;
        n           = 0;
        while (rises < 3 && n < 100) begin
            @(posedge clock);
            n++;
            #1;
            frame_start = 1'b0;
            @(negedge clock);
            if (pixel_valid && !pv) rises++;
            pv = pixel_valid;
        end
        checkOutput("abort_reached_pixel2", rises, 3);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("abort_valid", pixel_valid, 0);
        checkOutput("abort_busy", busy, 1);
        checkOutput("abort_count", frame_count, 0);
        checkOutput("abort_done", frame_done, 0);
        reset = 1'b1;
        for (int i = 0; i < NP; i++) model_buf[i] = '0;
        exp_frames = 16'd0;
        waitClear();
        runFrame(8'd255, 0, 1'b0, 1'b0, 1'b0, col);
        checkOutput("post_reset_pixel0", col, 24'h000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
